kband_onchip_mem_arbiter: RTL and testbench
===========================================

# kband_onchip_mem_arbiter

Two-requester arbiter sharing the single-port 16384×128-bit on-chip slave memory between the HPS-facing Avalon-MM master (port 0) and the KBand alignment core's sequence/result master (port 1). It accepts at most one access per cycle and drives the memory's address, byteenable, chipselect and write controls. Read data returns to the issuing requester with a registered `readdatavalid`. The block sits between the two masters and the on-chip memory instance in the KBandIPsubAffine system.

## Interface
Parameters:
- `ADDR_W`, 14: word address width; the memory holds 2^14 words.
- `DATA_W`, 128: data width.
- `BE_W`, `DATA_W/8`: byteenable width.

Ports (N = 0, 1):
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  **asynchronous, active-high** reset.
- `mN_address`  in  ADDR_W  requester word address.
- `mN_byteenable`  in  BE_W  write byte lanes.
- `mN_read`  in  1  read request.
- `mN_write`  in  1  write request.
- `mN_writedata`  in  DATA_W  write data.
- `mN_waitrequest`  out  1  request not accepted this cycle.
- `mN_readdata`  out  DATA_W  read data.
- `mN_readdatavalid`  out  1  `mN_readdata` is valid.
- `mem_address`  out  ADDR_W  memory address.
- `mem_byteenable`  out  BE_W  memory byteenable.
- `mem_chipselect`  out  1  memory access this cycle.
- `mem_write`  out  1  memory write.
- `mem_writedata`  out  DATA_W  memory write data.
- `mem_clken`  out  1  memory clock enable; tied to 1.
- `mem_readdata`  in  DATA_W  memory q; valid 1 cycle after the address cycle.
- `err_rw`  out  1  sticky flag: a requester asserted read and write together.

## Operation
- `reqN = mN_read | mN_write`. The grant is combinational from `req0`, `req1` and the registered priority pointer `last_q` (1 bit).
- Round-robin: if both requesters request, the one not equal to `last_q` wins. If only one requests, that one wins.
- Accepted access: the granted requester sees `mN_waitrequest=0`. `mem_*` carry its address, byteenable and writedata. `mem_chipselect=1`. `mem_write=mN_write`. On acceptance, `last_q` takes the granted index.
- Losing requester: `mN_waitrequest=1`. Its inputs must be held stable until it is accepted.
- No request: `mem_chipselect=0` and `mem_write=0`. `mem_address` holds its last value.
- Read tracking: `rdv_q[1:0]` is registered. Bit N is set in the cycle after an accepted read from N. `mN_readdatavalid=rdv_q[N]`.
- Read data: `mN_readdata=mem_readdata` on both ports. It is meaningful only while the matching valid bit is set.
- Read and write asserted together: the write executes, the read is ignored (no valid pulse), and `err_rw` sets. Only reset clears `err_rw`.
- `waitrequest` is never registered. Requesters may present a new request in the cycle after acceptance, giving back-to-back throughput of 1 access per cycle.

## Timing
- Reset values: `last_q=1` (so port 0 wins the first contention), `rdv_q=0`, `err_rw=0`. The combinational outputs follow from these values and the inputs.
- Read latency: exactly 1 cycle from the accept edge to `readdatavalid`. Data returns in request order.
- Write latency: the write is committed at the accept edge. There is no response phase.
- Read-after-write to the same address in consecutive cycles returns the new data. Read-during-write in the same cycle cannot occur, because only one access is granted per cycle.
- Reset asserted mid-operation: any pending `readdatavalid` is dropped, and the memory contents are untouched.
- Simultaneous requests every cycle: grants alternate 0,1,0,1. Worst-case wait is 1 cycle.

## Configuration
- `KBAND_ARB_ROUNDROBIN_EN` defined: round-robin arbitration as described above.
- Not defined: fixed priority. Port 0 always wins contention, `last_q` is removed, and port 1 may starve.
- All other behaviour is identical in both builds.

## Structure
- Shared package `kband_mem_pkg` holds `KB_MEM_ADDR_W=14`, `KB_MEM_DATA_W=128`, `KB_MEM_BE_W=16` and the requester index typedef `kb_req_idx_t`.
- One natural sub-module: `kband_rr_arb2`, holding the 2-way grant logic and priority pointer, with `req[1:0]` in and `gnt[1:0]` out.

## Test plan
- Reset then idle: `mem_chipselect=0`, both `waitrequest=0`, both `readdatavalid=0`, `err_rw=0`.
- Port 0 writes 0x0123…CDEF at address 0x0010 with byteenable 0xFFFF, then reads 0x0010 in the next cycle -> `m0_readdatavalid` pulses 1 cycle after read acceptance with the same data.
- Both ports read continuously (addresses 0x0000 for port 0, 0x3FFF for port 1) -> grants alternate starting with port 0, and each port gets a valid every other cycle with the correct data.
- Byte-lane write from port 1 with byteenable 0x0001 and data 0xAA onto a word holding all zeros -> readback is 0x…00AA.
- `m1_read=m1_write=1` at address 0x0020 -> the write is committed, no `m1_readdatavalid`, and `err_rw` is set and stays 1 until reset.
- Reset asserted in the cycle after an accepted read -> no `readdatavalid` pulse. Without `KBAND_ARB_ROUNDROBIN_EN`, continuous dual requests show port 1 held in `waitrequest`.

Source files
------------

// File: rtl/kband_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kband_mem_pkg
// Description : Shared geometry and requester index type for the KBand
//               on-chip memory arbiter (16384 x 128-bit single-port memory).
// Revision    : 1.0 - initial release
// ============================================================================
package kband_mem_pkg;

    localparam int KB_MEM_ADDR_W = 14;
    localparam int KB_MEM_DATA_W = 128;
    localparam int KB_MEM_BE_W   = 16;

    // Requester index: port 0 = HPS master, port 1 = KBand core master.
    typedef enum logic {
        KB_REQ_M0 = 1'b0,
        KB_REQ_M1 = 1'b1
    } kb_req_idx_t;

endpackage : kband_mem_pkg
`default_nettype wire

// File: rtl/kband_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : kband_rr_arb2
// Description : Two-way combinational grant with a one-bit priority pointer.
//               KBAND_ARB_ROUNDROBIN_EN defined : round-robin, the requester
//               not granted last wins contention (pointer resets to 1 so
//               port 0 wins first).
//               Undefined : fixed priority, port 0 always wins, no pointer.
// Ports       : clk, reset (async, active-high)
//               req[1:0] in  - request per port
//               gnt[1:0] out - one-hot (or zero) grant, same cycle
// Revision    : 1.0 - initial release
// ============================================================================
module kband_rr_arb2
    import kband_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef KBAND_ARB_ROUNDROBIN_EN
    kb_req_idx_t last_q;
    kb_req_idx_t last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contention: the port other than the last winner goes next.
            2'b11:   gnt = (last_q == KB_REQ_M1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            last_d = KB_REQ_M0;
        end else if (gnt[1]) begin
            last_d = KB_REQ_M1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= KB_REQ_M1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority is purely combinational; the clock and reset are kept
    // on the port list so both builds share one instantiation.
    logic w_unused;
    assign w_unused = clk ^ reset;

    assign gnt[0] = req[0];
    assign gnt[1] = req[1] & ~req[0];
`endif

endmodule : kband_rr_arb2
`default_nettype wire

// File: rtl/kband_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : kband_onchip_mem_arbiter
// Description : Shares the single-port on-chip memory between the HPS Avalon
//               master (m0) and the KBand core master (m1). One access per
//               cycle, combinational waitrequest, 1-cycle registered
//               readdatavalid. Build option KBAND_ARB_ROUNDROBIN_EN selects
//               round-robin (defined) or fixed port-0 priority (undefined).
// Ports       : clk, reset (async, active-high)
//               mN_* : requester Avalon-MM slave side (N = 0, 1)
//               mem_*: memory control / data, mem_clken tied high
//               err_rw: sticky, a requester raised read and write together
// Revision    : 1.0 - initial release
// ============================================================================
module kband_onchip_mem_arbiter
    import kband_mem_pkg::*;
#(
    parameter int ADDR_W = KB_MEM_ADDR_W,
    parameter int DATA_W = KB_MEM_DATA_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              err_rw
);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        rdv_q;
    logic [1:0]        rdv_d;
    logic              err_rw_q;
    logic              err_rw_d;

    assign w_req = {m1_read | m1_write, m0_read | m0_write};

    kband_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_req),
        .gnt   (w_gnt)
    );

    assign m0_waitrequest = w_req[0] & ~w_gnt[0];
    assign m1_waitrequest = w_req[1] & ~w_gnt[1];

    // Memory side mux. The address falls back to the last issued address
    // when idle so the memory address bus does not toggle needlessly.
    always_comb begin
        mem_address    = addr_q;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (w_gnt[0]) begin
            mem_address    = m0_address;
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
        end else if (w_gnt[1]) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
        end
    end

    assign addr_d = mem_address;

    // A read that arrives together with a write is dropped: the write wins
    // and no valid pulse is produced.
    assign rdv_d = {w_gnt[1] & m1_read & ~m1_write,
                    w_gnt[0] & m0_read & ~m0_write};

    assign err_rw_d = err_rw_q | (m0_read & m0_write) | (m1_read & m1_write);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            rdv_q    <= 2'b00;
            err_rw_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            rdv_q    <= rdv_d;
            err_rw_q <= err_rw_d;
        end
    end

    assign m0_readdatavalid = rdv_q[0];
    assign m1_readdatavalid = rdv_q[1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign mem_clken        = 1'b1;
    assign err_rw           = err_rw_q;

endmodule : kband_onchip_mem_arbiter
`default_nettype wire

// File: tb/tb_kband_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_kband_onchip_mem_arbiter
// Description : Self-checking bench for kband_onchip_mem_arbiter. Includes a
//               behavioural single-port memory on the mem_* side and a
//               reference model of arbitration, memory contents and
//               response timing. Honours KBAND_ARB_ROUNDROBIN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kband_onchip_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 128;
    localparam int BW = 16;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;

    logic [AW-1:0] m0_address,    m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_read,       m1_read;
    logic          m0_write,      m1_write;
    logic [DW-1:0] m0_writedata,  m1_writedata;
    logic          m0_waitrequest,   m1_waitrequest;
    logic [DW-1:0] m0_readdata,      m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata;
    logic [DW-1:0] mem_readdata = '0;
    logic          err_rw;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    kband_onchip_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .err_rw(err_rw)
    );

    // ---------------- behavioural on-chip memory (device side) -------------
    logic [DW-1:0] fx_mem [int];
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (mem_chipselect) begin
            w = fx_mem.exists(int'(mem_address)) ? fx_mem[int'(mem_address)] : '0;
            if (mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byteenable[b]) w[b*8 +: 8] = mem_writedata[b*8 +: 8];
                fx_mem[int'(mem_address)] = w;
            end else begin
                mem_readdata <= w;
            end
        end
    end

    // ---------------- reference model -------------------------------------
    logic [DW-1:0] exp_mem [int];
    int            m_last      = 1;
    int            m_last_addr = 0;
    bit            exp_rdv0, exp_rdv1, exp_err;
    logic [DW-1:0] exp_rd;

    function automatic logic [DW-1:0] model_rd(input int a);
        return exp_mem.exists(a) ? exp_mem[a] : '0;
    endfunction

    // Returns granted port, or -1 when nobody requests.
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef KBAND_ARB_ROUNDROBIN_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d);
        if (p == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    task automatic idle_all();
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
    endtask

    // One bus cycle: inputs are already applied (posedge+1). Checks the
    // combinational outputs mid-cycle, advances the model at the edge and
    // checks the registered responses just after it. Returns the grant.
    task automatic step(input string tag, output int g);
        bit r0, r1, wr, rd;
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] d, nv;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        @(negedge clk);
        g = pick(r0, r1);
        chk({tag, ":wait0"}, DW'(m0_waitrequest), DW'(r0 && g != 0));
        chk({tag, ":wait1"}, DW'(m1_waitrequest), DW'(r1 && g != 1));
        chk({tag, ":cs"},    DW'(mem_chipselect), DW'(g >= 0));
        if (g == 0) begin rd = m0_read; wr = m0_write; a = m0_address; be = m0_byteenable; d = m0_writedata; end
        else        begin rd = m1_read; wr = m1_write; a = m1_address; be = m1_byteenable; d = m1_writedata; end
        if (g >= 0) begin
            chk({tag, ":mwr"},  DW'(mem_write),   DW'(wr));
            chk({tag, ":addr"}, DW'(mem_address), DW'(a));
            if (wr) begin
                chk({tag, ":be"},    DW'(mem_byteenable), DW'(be));
                chk({tag, ":wdata"}, mem_writedata,       d);
            end
        end else begin
            chk({tag, ":mwr"},       DW'(mem_write),   '0);
            chk({tag, ":addr_hold"}, DW'(mem_address), DW'(m_last_addr));
        end
        if ((m0_read && m0_write) || (m1_read && m1_write)) exp_err = 1;
        @(posedge clk);
        exp_rdv0 = 0;
        exp_rdv1 = 0;
        if (g >= 0) begin
            if (wr) begin
                nv = model_rd(int'(a));
                for (int b = 0; b < BW; b++) if (be[b]) nv[b*8 +: 8] = d[b*8 +: 8];
                exp_mem[int'(a)] = nv;
            end else if (rd) begin
                exp_rd = model_rd(int'(a));
                if (g == 0) exp_rdv0 = 1; else exp_rdv1 = 1;
            end
            m_last      = g;
            m_last_addr = int'(a);
        end
        #1;
        chk({tag, ":rdv0"}, DW'(m0_readdatavalid), DW'(exp_rdv0));
        chk({tag, ":rdv1"}, DW'(m1_readdatavalid), DW'(exp_rdv1));
        chk({tag, ":err"},  DW'(err_rw),           DW'(exp_err));
        if (exp_rdv0) chk({tag, ":rdata0"}, m0_readdata, exp_rd);
        if (exp_rdv1) chk({tag, ":rdata1"}, m1_readdata, exp_rd);
    endtask

    task automatic model_reset();
        m_last = 1; m_last_addr = 0; exp_rdv0 = 0; exp_rdv1 = 0; exp_err = 0;
    endtask

    // ---------------- stimulus ----------------------------------------------
    initial begin
        int g;
        bit hold0, hold1;
        logic [DW-1:0] rnd;
        idle_all();
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and idle behaviour
        step("idle", g);
        chk("clken", DW'(mem_clken), DW'(1));

        // Port 0 write then read-after-write to 0x0010
        drive(0, 0, 1, 14'h0010, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF);
        step("p0_wr", g);
        drive(0, 1, 0, 14'h0010, 16'hFFFF, '0);
        step("p0_rd", g);
        chk("p0_raw_data", m0_readdata, 128'h0123456789ABCDEF0123456789ABCDEF);
        idle_all();
        step("p0_idle", g);

        // Preload the two corner addresses, then dual continuous reads
        drive(0, 0, 1, 14'h0000, 16'hFFFF, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
        step("pre0", g);
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 1, 14'h3FFF, 16'hFFFF, 128'h5A5A_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999);
        step("pre1", g);
        drive(0, 1, 0, 14'h0000, 16'h0000, '0);
        drive(1, 1, 0, 14'h3FFF, 16'h0000, '0);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("dual%0d", i), g);
            if (i == 0) chk("dual_first_grant", DW'(g), DW'(0));
        end
        idle_all();
        step("dual_idle", g);

        // Byte-lane write from port 1 onto an all-zero word
        drive(1, 0, 1, 14'h0030, 16'h0001, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFAA);
        step("be_wr", g);
        drive(1, 1, 0, 14'h0030, 16'h0000, '0);
        step("be_rd", g);
        chk("be_lane_data", m1_readdata, 128'h0000_0000_0000_0000_0000_0000_0000_00AA);
        idle_all();

        // Read and write together: write wins, no valid, sticky error
        drive(1, 1, 1, 14'h0020, 16'hFFFF, 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D);
        step("rw_both", g);
        idle_all();
        step("rw_idle", g);
        drive(0, 1, 0, 14'h0020, 16'h0000, '0);
        step("rw_check", g);
        idle_all();

        // Randomised traffic; a waiting port keeps its request stable
        hold0 = 0; hold1 = 0;
        for (int i = 0; i < 200; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!((p == 0) ? hold0 : hold1)) begin
                    int op;
                    op  = int'($urandom_range(0, 3));
                    rnd = {$urandom, $urandom, $urandom, $urandom};
                    drive(p, op == 1, op >= 2, 14'h0100 + 14'($urandom_range(0, 5)),
                          16'($urandom), rnd);
                end
            end
            step($sformatf("rnd%0d", i), g);
            hold0 = (m0_read | m0_write) && g != 0;
            hold1 = (m1_read | m1_write) && g != 1;
        end
        idle_all();
        step("rnd_idle", g);

        // Reset in the cycle after an accepted read: the valid is dropped
        drive(0, 1, 0, 14'h0010, 16'h0000, '0);
        @(negedge clk);
        chk("rst_rd_accept", DW'(m0_waitrequest), DW'(0));
        @(posedge clk);
        reset = 1'b1;
        idle_all();
        #1;
        chk("rst_rdv0", DW'(m0_readdatavalid), DW'(0));
        chk("rst_err",  DW'(err_rw),           DW'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        step("post_rst_idle", g);
        drive(0, 1, 0, 14'h0010, 16'h0000, '0);
        step("post_rst_rd", g);
        chk("post_rst_data", m0_readdata, 128'h0123456789ABCDEF0123456789ABCDEF);
        idle_all();
        step("end_idle", g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_kband_onchip_mem_arbiter
`default_nettype wire
